// File: rtl/floo_eoc_monitor.sv
// floo_eoc_monitor
//   Watches the end-of-computation (EOC) levels of a set of compute-tile
//   clusters after an arm pulse. It records which clusters have finished,
//   latches each cluster's exit status at its first EOC, and remembers the
//   first failing cluster. Once every cluster has finished it waits a fixed
//   drain time before reporting done/pass. A watchdog ends the run in
//   TIMEOUT if some cluster never finishes.
//
// Ports
//   clk_i         clock (all state changes on its rising edge)
//   rst_i         synchronous active-high reset
//   start_i       arm pulse, only honoured in IDLE
//   eoc_i         per-cluster end-of-computation level
//   fail_i        per-cluster nonzero exit code, valid with its eoc_i bit
//   eoc_seen_o    sticky per-cluster EOC flags
//   done_o        sticky, high in DONE
//   pass_o        high in DONE when no cluster reported a failure
//   timeout_o     sticky, high in TIMEOUT
//   first_fail_o  index of the first failing cluster (lowest index on a tie)
//   cycle_cnt_o   cycles spent in RUN, saturating
module floo_eoc_monitor #(
  parameter int unsigned NumClusters   = 4,
  parameter int unsigned DrainCycles   = 10,
  parameter logic [31:0] TimeoutCycles = 32'd1000000,
  localparam int unsigned FfW          = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NumClusters-1:0] eoc_i,
  input  logic [NumClusters-1:0] fail_i,
  output logic [NumClusters-1:0] eoc_seen_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [FfW-1:0]         first_fail_o,
  output logic [31:0]            cycle_cnt_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [15:0] DRAIN_LOAD = 16'(DrainCycles - 1);
  localparam logic [31:0] TO_LAST    = TimeoutCycles - 32'd1;

  logic [2:0]             state_reg, state_next;
  logic [NumClusters-1:0] eoc_seen_reg;
  logic [NumClusters-1:0] fail_reg;
  logic [FfW-1:0]         first_fail_reg;
  logic [31:0]            cycle_cnt_reg;
  logic [15:0]            drain_cnt_reg;
  logic                   done_reg, pass_reg, timeout_reg;

  logic                   in_run;
  logic [NumClusters-1:0] new_eoc;
  logic [NumClusters-1:0] new_fail;
  logic                   all_eoc;
  logic                   timeout_hit;
  logic [FfW-1:0]         ff_idx;

  assign in_run = (state_reg == ST_RUN);

  // A cluster's flags are only written on its first EOC edge inside RUN,
  // so later fail_i wiggles and eoc_i deassertion are ignored.
  for (genvar gi = 0; gi < NumClusters; gi++) begin : g_cluster
    assign new_eoc[gi]  = in_run & eoc_i[gi] & ~eoc_seen_reg[gi];
    assign new_fail[gi] = new_eoc[gi] & fail_i[gi];
  end

  // Including the live eoc_i lets the final EOC close RUN in its own cycle.
  assign all_eoc     = &(eoc_seen_reg | eoc_i);
  assign timeout_hit = (cycle_cnt_reg == TO_LAST);

  // Lowest-index failing cluster among those finishing this cycle.
  always_comb begin
    ff_idx = '0;
    for (int i = NumClusters - 1; i >= 0; i--) begin
      if (new_fail[i]) ff_idx = FfW'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_i) state_next = ST_RUN;
      ST_RUN: begin
        // Completion takes priority over the watchdog in the same cycle.
        if (all_eoc)          state_next = ST_DRAIN;
        else if (timeout_hit) state_next = ST_TIMEOUT;
      end
      ST_DRAIN:   if (drain_cnt_reg == 16'd0) state_next = ST_DONE;
      ST_DONE:    state_next = ST_DONE;
      ST_TIMEOUT: state_next = ST_TIMEOUT;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      eoc_seen_reg   <= '0;
      fail_reg       <= '0;
      first_fail_reg <= '0;
      cycle_cnt_reg  <= '0;
      drain_cnt_reg  <= '0;
      done_reg       <= 1'b0;
      pass_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      eoc_seen_reg <= eoc_seen_reg | new_eoc;
      fail_reg     <= fail_reg | new_fail;

      // Only the first cycle with any failure captures the index.
      if ((fail_reg == '0) && (new_fail != '0)) first_fail_reg <= ff_idx;

      if (in_run && (cycle_cnt_reg != '1)) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;

      // Loading DrainCycles-1 and leaving on the zero cycle gives exactly
      // DrainCycles edges between DRAIN entry and DONE entry.
      if (in_run && (state_next == ST_DRAIN)) begin
        drain_cnt_reg <= DRAIN_LOAD;
      end else if ((state_reg == ST_DRAIN) && (drain_cnt_reg != 16'd0)) begin
        drain_cnt_reg <= drain_cnt_reg - 16'd1;
      end

      // Status flags are decoded from the next state so they line up with
      // the state register.
      done_reg    <= (state_next == ST_DONE);
      pass_reg    <= (state_next == ST_DONE) && ((fail_reg | new_fail) == '0);
      timeout_reg <= (state_next == ST_TIMEOUT);
    end
  end

  assign eoc_seen_o   = eoc_seen_reg;
  assign done_o       = done_reg;
  assign pass_o       = pass_reg;
  assign timeout_o    = timeout_reg;
  assign first_fail_o = first_fail_reg;
  assign cycle_cnt_o  = cycle_cnt_reg;

endmodule

// File: tb/tb_floo_eoc_monitor.sv
// tb_floo_eoc_monitor
//   Self-checking bench for floo_eoc_monitor (4 clusters, drain 10,
//   watchdog 50). Each run is described by the RUN cycle at which every
//   cluster first raises EOC (or never) and its exit status at that moment;
//   the expected outputs after every edge are derived from that schedule.
module tb_floo_eoc_monitor;

  localparam int NC   = 4;
  localparam int DC   = 10;
  localparam int TO   = 50;
  localparam int KMAX = 64;

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic [NC-1:0] eoc_i;
  logic [NC-1:0] fail_i;
  logic [NC-1:0] eoc_seen_o;
  logic          done_o;
  logic          pass_o;
  logic          timeout_o;
  logic [1:0]    first_fail_o;
  logic [31:0]   cycle_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Run schedule: RUN cycle of first EOC per cluster (-1 = never) and the
  // exit status presented in that cycle.
  int arrive [NC];
  bit plan_fail [NC];

  floo_eoc_monitor #(
    .NumClusters  (NC),
    .DrainCycles  (DC),
    .TimeoutCycles(32'(TO))
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .eoc_i       (eoc_i),
    .fail_i      (fail_i),
    .eoc_seen_o  (eoc_seen_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .timeout_o   (timeout_o),
    .first_fail_o(first_fail_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    eoc_i   = '0;
    fail_i  = '0;
    @(posedge clk); #1;
    rst_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b1;
    eoc_i   = '1;
    fail_i  = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (eoc_seen_o !== '0 || done_o !== 1'b0 || pass_o !== 1'b0 || timeout_o !== 1'b0 ||
        first_fail_o !== '0 || cycle_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL reset: seen=%b done=%b pass=%b to=%b ff=%0d cnt=%0d, required all zero",
               eoc_seen_o, done_o, pass_o, timeout_o, first_fail_o, cycle_cnt_o);
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
    eoc_i   = '0;
    fail_i  = '0;
    $display("test_reset: done");
  endtask

  // Hold eoc_i high without a start pulse; nothing may be recorded.
  task automatic idle_hold(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      start_i = 1'b0;
      eoc_i   = '1;
      fail_i  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      checks++;
      if (eoc_seen_o !== '0 || cycle_cnt_o !== 32'd0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
        failures++;
        $display("FAIL %s idle cycle %0d: seen=%b cnt=%0d done=%b to=%b, required 0 0 0 0",
                 name, i, eoc_seen_o, cycle_cnt_o, done_o, timeout_o);
      end
    end
  endtask

  // Start a run from IDLE and follow the schedule in arrive/plan_fail.
  // abort_k >= 0 pulses reset during RUN cycle abort_k instead of finishing.
  task automatic run_scenario(input string name, input int abort_k);
    int            last;
    bit            drain;
    int            endk;
    int            kk;
    int            best;
    int            errs;
    logic [NC-1:0] e, f, seen_exp;
    logic [1:0]    ff_exp;
    bit            any_fail;
    bit            done_exp, pass_exp, to_exp;
    logic [31:0]   cnt_exp;

    last  = -1;
    drain = 1'b1;
    for (int c = 0; c < NC; c++) begin
      if (arrive[c] < 0) drain = 1'b0;
      else if (arrive[c] > last) last = arrive[c];
    end
    if (last > TO - 1) drain = 1'b0;
    // Last RUN cycle: completion cycle, or the watchdog cycle.
    endk = drain ? last : TO - 1;
    errs = 0;

    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (cycle_cnt_o !== 32'd0 || eoc_seen_o !== '0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      errs++;
      $display("FAIL %s start edge: cnt=%0d seen=%b done=%b to=%b, required 0 0 0 0",
               name, cycle_cnt_o, eoc_seen_o, done_o, timeout_o);
    end

    for (int k = 0; k < KMAX; k++) begin
      if (k == abort_k) begin
        rst_i   = 1'b1;
        eoc_i   = '0;
        fail_i  = '0;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checks++;
        if (eoc_seen_o !== '0 || done_o !== 1'b0 || pass_o !== 1'b0 || timeout_o !== 1'b0 ||
            first_fail_o !== '0 || cycle_cnt_o !== 32'd0) begin
          failures++;
          errs++;
          $display("FAIL %s abort: seen=%b done=%b pass=%b to=%b ff=%0d cnt=%0d, required all zero",
                   name, eoc_seen_o, done_o, pass_o, timeout_o, first_fail_o, cycle_cnt_o);
        end
        $display("%s: reset at RUN cycle %0d, errors=%0d", name, k, errs);
        return;
      end

      for (int c = 0; c < NC; c++) begin
        if (arrive[c] < 0 || k < arrive[c]) e[c] = 1'b0;
        else if (k == arrive[c])            e[c] = 1'b1;
        else                                e[c] = 1'($urandom_range(0, 1));
        f[c] = (k == arrive[c]) ? plan_fail[c] : 1'($urandom_range(0, 1));
      end
      eoc_i   = e;
      fail_i  = f;
      start_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;

      kk       = (k < endk) ? k : endk;
      seen_exp = '0;
      any_fail = 1'b0;
      best     = -1;
      ff_exp   = '0;
      for (int c = 0; c < NC; c++) begin
        if (arrive[c] >= 0 && arrive[c] <= kk) begin
          seen_exp[c] = 1'b1;
          if (plan_fail[c]) begin
            any_fail = 1'b1;
            if (best < 0 || arrive[c] < arrive[best]) best = c;
          end
        end
      end
      if (best >= 0) ff_exp = 2'(best);
      cnt_exp  = 32'(kk + 1);
      done_exp = drain && (k >= last + DC);
      to_exp   = !drain && (k >= TO - 1);
      pass_exp = done_exp && !any_fail;

      checks++;
      if (eoc_seen_o !== seen_exp || cycle_cnt_o !== cnt_exp || done_o !== done_exp ||
          pass_o !== pass_exp || timeout_o !== to_exp || first_fail_o !== ff_exp) begin
        failures++;
        errs++;
        $display("FAIL %s cycle %0d: seen=%b cnt=%0d done=%b pass=%b to=%b ff=%0d, required seen=%b cnt=%0d done=%b pass=%b to=%b ff=%0d",
                 name, k, eoc_seen_o, cycle_cnt_o, done_o, pass_o, timeout_o, first_fail_o,
                 seen_exp, cnt_exp, done_exp, pass_exp, to_exp, ff_exp);
      end
    end
    start_i = 1'b0;
    eoc_i   = '0;
    fail_i  = '0;
    $display("%s: arrive=%0d,%0d,%0d,%0d fail=%b%b%b%b drain=%0d errors=%0d",
             name, arrive[0], arrive[1], arrive[2], arrive[3],
             plan_fail[3], plan_fail[2], plan_fail[1], plan_fail[0], drain, errs);
  endtask

  task automatic set_plan(input int a0, input int a1, input int a2, input int a3,
                          input logic [3:0] fl);
    arrive[0] = a0;
    arrive[1] = a1;
    arrive[2] = a2;
    arrive[3] = a3;
    for (int c = 0; c < NC; c++) plan_fail[c] = fl[c];
  endtask

  task automatic test_pass();
    do_reset();
    set_plan(5, 9, 9, 20, 4'b0000);
    run_scenario("test_pass", -1);
  endtask

  task automatic test_fail();
    do_reset();
    set_plan(5, 9, 9, 20, 4'b0110);
    run_scenario("test_fail", -1);
  endtask

  task automatic test_timeout();
    do_reset();
    set_plan(3, 17, 40, -1, 4'b0100);
    run_scenario("test_timeout", -1);
  endtask

  task automatic test_last_at_limit();
    do_reset();
    set_plan(0, 49, 12, 30, 4'b1000);
    run_scenario("test_last_at_limit", -1);
    do_reset();
    set_plan(0, 50, 12, 30, 4'b0000);
    run_scenario("test_last_after_limit", -1);
  endtask

  task automatic test_idle_ignore();
    do_reset();
    idle_hold("test_idle_ignore", 10);
    set_plan(0, 0, 0, 0, 4'b1010);
    run_scenario("test_idle_ignore", -1);
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    set_plan(2, 6, 4, 8, 4'b0001);
    run_scenario("test_reset_in_drain", 11);
    idle_hold("test_reset_in_drain", 5);
    set_plan(1, 2, 3, 4, 4'b0000);
    run_scenario("test_reset_in_drain_rerun", -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_reset();
      for (int c = 0; c < NC; c++) begin
        arrive[c]    = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 52));
        plan_fail[c] = ($urandom_range(0, 3) == 0);
      end
      run_scenario("test_random", -1);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    eoc_i   = '0;
    fail_i  = '0;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_last_at_limit();
    test_idle_ignore();
    test_reset_in_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
